// File: rtl/conv_seq_engine.sv
// conv_seq_engine: convolution layer evaluated one product per cycle on a single signed MAC.
// Latency: each output element takes CLEAR + K MAC cycles + EMIT, where K = channel*k_size*k_size.
//   With y_ready held high that is K+2 cycles per element, and done pulses one cycle after the final accept.
// Backpressure: while y_ready is low the engine waits in EMIT and holds y_data, y_depth and y_pos steady.
// Ports: clk, rst (async active-low); start launches a run and latches a, b, c and relu_en;
//   busy covers the whole run; y_valid/y_ready/y_data/y_depth/y_pos stream the results
//   in order depth, output row, output column; done is a one-cycle pulse at the end of a run.
module conv_seq_engine #(
  parameter int width     = 8,
  parameter int out_width = 8,
  parameter int acc_width = 24,
  parameter int col       = 3,
  parameter int row       = 3,
  parameter int channel   = 3,
  parameter int depth     = 2,
  parameter int k_size    = 2,
  parameter int stride    = 1,
  parameter int pad_size  = 1,
  localparam int col_size = (col - k_size + 2*pad_size) / stride + 1,
  localparam int row_size = (row - k_size + 2*pad_size) / stride + 1,
  localparam int dep_w    = (depth > 1) ? $clog2(depth) : 1,
  localparam int pos_w    = (col_size*row_size > 1) ? $clog2(col_size*row_size) : 1
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      start,
  input  logic                                      relu_en,
  input  logic [col*row*channel*width-1:0]          a,
  input  logic [depth*channel*k_size*k_size*width-1:0] b,
  input  logic [depth*out_width-1:0]                c,
  output logic                                      busy,
  output logic                                      y_valid,
  input  logic                                      y_ready,
  output logic [out_width-1:0]                      y_data,
  output logic [dep_w-1:0]                          y_depth,
  output logic [pos_w-1:0]                          y_pos,
  output logic                                      done
);

  localparam int m_w    = (channel > 1) ? $clog2(channel) : 1;
  localparam int k_w    = (k_size > 1) ? $clog2(k_size) : 1;
  localparam int oc_w   = (col_size > 1) ? $clog2(col_size) : 1;
  localparam int or_w   = (row_size > 1) ? $clog2(row_size) : 1;
  localparam int a_bits = col*row*channel*width;
  localparam int b_bits = depth*channel*k_size*k_size*width;
  localparam int c_bits = depth*out_width;

  // Largest positive output value; its bitwise inverse is the most negative one.
  localparam logic signed [acc_width-1:0] sat_max = acc_width'((2 ** (out_width-1)) - 1);
  localparam logic signed [acc_width-1:0] sat_min = ~sat_max;

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_ACC, S_EMIT, S_DONE} state_t;

  state_t                       state_q, state_d;
  logic [a_bits-1:0]            a_q;
  logic [b_bits-1:0]            b_q;
  logic [c_bits-1:0]            c_q;
  logic                         relu_q;
  logic [m_w-1:0]               m;
  logic [k_w-1:0]               n, o;
  logic [oc_w-1:0]              ocol;
  logic [or_w-1:0]              orow;
  logic [dep_w-1:0]             p;
  logic [pos_w-1:0]             pos;
  logic signed [acc_width-1:0]  acc;

  logic [31:0]                  ir_p, ic_p, a_idx, b_idx;
  logic                         in_bounds;
  logic signed [width-1:0]      a_op, b_op;
  logic signed [2*width-1:0]    prod;
  logic signed [out_width-1:0]  bias;
  logic                         mac_last, ocol_last, orow_last, p_last, run_last;

  assign mac_last  = (m == m_w'(channel-1)) && (n == k_w'(k_size-1)) && (o == k_w'(k_size-1));
  assign ocol_last = (ocol == oc_w'(col_size-1));
  assign orow_last = (orow == or_w'(row_size-1));
  assign p_last    = (p == dep_w'(depth-1));
  assign run_last  = ocol_last && orow_last && p_last;

  // Operand selection. Row/column coordinates are kept offset by pad_size so they
  // never go negative; anything landing in the padding ring reads as zero, which
  // avoids ever building a padded copy of the input tensor.
  always_comb begin
    ir_p      = 32'(orow) * 32'(stride) + 32'(n);
    ic_p      = 32'(ocol) * 32'(stride) + 32'(o);
    in_bounds = (ir_p >= 32'(pad_size)) && (ir_p < 32'(row + pad_size)) &&
                (ic_p >= 32'(pad_size)) && (ic_p < 32'(col + pad_size));
    a_idx     = 32'(m) * 32'(row*col) + (ir_p - 32'(pad_size)) * 32'(col) +
                (ic_p - 32'(pad_size));
    b_idx     = (32'(p) * 32'(channel) + 32'(m)) * 32'(k_size*k_size) +
                32'(n) * 32'(k_size) + 32'(o);
    a_op      = in_bounds ? width'(a_q >> (a_idx * 32'(width))) : '0;
    b_op      = width'(b_q >> (b_idx * 32'(width)));
    prod      = (2*width)'(a_op) * (2*width)'(b_op);
    bias      = out_width'(c_q >> (32'(p) * 32'(out_width)));
  end

  // ReLU acts on the full-precision sum (after bias), then the result is clamped.
  always_comb begin
    if (relu_q && acc[acc_width-1]) begin
      y_data = '0;
    end else if (acc > sat_max) begin
      y_data = {1'b0, {(out_width-1){1'b1}}};
    end else if (acc < sat_min) begin
      y_data = {1'b1, {(out_width-1){1'b0}}};
    end else begin
      y_data = acc[out_width-1:0];
    end
  end

  assign y_depth = p;
  assign y_pos   = pos;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    y_valid = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        busy    = 1'b1;
        state_d = S_ACC;
      end
      S_ACC: begin
        busy = 1'b1;
        if (mac_last) begin
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        busy    = 1'b1;
        y_valid = 1'b1;
        if (y_ready) begin
          state_d = run_last ? S_DONE : S_CLEAR;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q    <= '0;
      b_q    <= '0;
      c_q    <= '0;
      relu_q <= 1'b0;
      m      <= '0;
      n      <= '0;
      o      <= '0;
      ocol   <= '0;
      orow   <= '0;
      p      <= '0;
      pos    <= '0;
      acc    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            a_q    <= a;
            b_q    <= b;
            c_q    <= c;
            relu_q <= relu_en;
            ocol   <= '0;
            orow   <= '0;
            p      <= '0;
            pos    <= '0;
          end
        end
        S_CLEAR: begin
          acc <= acc_width'(bias);
          m   <= '0;
          n   <= '0;
          o   <= '0;
        end
        S_ACC: begin
          acc <= acc + acc_width'(prod);
          // Kernel column innermost, then kernel row, then channel.
          if (o == k_w'(k_size-1)) begin
            o <= '0;
            if (n == k_w'(k_size-1)) begin
              n <= '0;
              if (m == m_w'(channel-1)) begin
                m <= '0;
              end else begin
                m <= m + 1'b1;
              end
            end else begin
              n <= n + 1'b1;
            end
          end else begin
            o <= o + 1'b1;
          end
        end
        S_EMIT: begin
          if (y_ready) begin
            if (ocol_last) begin
              ocol <= '0;
              if (orow_last) begin
                orow <= '0;
                pos  <= '0;
                p    <= p_last ? '0 : p + 1'b1;
              end else begin
                orow <= orow + 1'b1;
                pos  <= pos + 1'b1;
              end
            end else begin
              ocol <= ocol + 1'b1;
              pos  <= pos + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_seq_engine.sv
// tb_conv_seq_engine: bench for conv_seq_engine with a loop-based convolution reference.
// Covers reset state, timing, saturation, ReLU, bias, backpressure, restart/abort control
// and a strided, unpadded configuration on a second instance.
module tb_conv_seq_engine;

  localparam int W = 8, OW = 8, COL = 3, ROW = 3, CH = 3, DEP = 2, KS = 2, STRIDE = 1, PAD = 1;
  localparam int CS = (COL - KS + 2*PAD) / STRIDE + 1;
  localparam int RS = (ROW - KS + 2*PAD) / STRIDE + 1;
  localparam int K = CH*KS*KS;
  localparam int NPOS = CS*RS;
  localparam int TOT = DEP*NPOS;

  logic clk = 1'b0;
  logic rst, start, relu_en, y_ready;
  logic [COL*ROW*CH*W-1:0]     a;
  logic [DEP*CH*KS*KS*W-1:0]   b;
  logic [DEP*OW-1:0]           c;
  logic busy, y_valid, done;
  logic [OW-1:0] y_data;
  logic [0:0]    y_depth;
  logic [3:0]    y_pos;

  logic start2, y_ready2;
  logic [127:0] a2;
  logic [31:0]  b2;
  logic [7:0]   c2;
  logic busy2, y2_valid, done2;
  logic [7:0] y2_data;
  logic [0:0] y2_depth;
  logic [1:0] y2_pos;

  int checks = 0;
  int failures = 0;
  int av [COL*ROW*CH];
  int bv [DEP*CH*KS*KS];
  int cv [DEP];

  always #5 clk = ~clk;

  conv_seq_engine #(
    .width(W), .out_width(OW), .acc_width(24), .col(COL), .row(ROW), .channel(CH),
    .depth(DEP), .k_size(KS), .stride(STRIDE), .pad_size(PAD)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .relu_en(relu_en), .a(a), .b(b), .c(c),
    .busy(busy), .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data),
    .y_depth(y_depth), .y_pos(y_pos), .done(done)
  );

  conv_seq_engine #(
    .width(8), .out_width(8), .acc_width(24), .col(4), .row(4), .channel(1),
    .depth(1), .k_size(2), .stride(2), .pad_size(0)
  ) dut2 (
    .clk(clk), .rst(rst), .start(start2), .relu_en(relu_en), .a(a2), .b(b2), .c(c2),
    .busy(busy2), .y_valid(y2_valid), .y_ready(y_ready2), .y_data(y2_data),
    .y_depth(y2_depth), .y_pos(y2_pos), .done(done2)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Direct evaluation of one output element: bias plus the dot product over
  // channels and kernel taps, with out-of-range taps contributing nothing.
  function automatic int model(int p, int orow, int ocol);
    int s = cv[p];
    for (int m = 0; m < CH; m++)
      for (int kr = 0; kr < KS; kr++)
        for (int kc = 0; kc < KS; kc++) begin
          int ir = orow*STRIDE + kr - PAD;
          int ic = ocol*STRIDE + kc - PAD;
          if (ir >= 0 && ir < ROW && ic >= 0 && ic < COL)
            s += av[m*ROW*COL + ir*COL + ic] * bv[((p*CH + m)*KS + kr)*KS + kc];
        end
    if (relu_en && s < 0) s = 0;
    if (s > 127) s = 127;
    if (s < -128) s = -128;
    return s;
  endfunction

  task automatic pack();
    for (int i = 0; i < COL*ROW*CH; i++) a[i*W +: W] = av[i][W-1:0];
    for (int i = 0; i < DEP*CH*KS*KS; i++) b[i*W +: W] = bv[i][W-1:0];
    for (int i = 0; i < DEP; i++) c[i*OW +: OW] = cv[i][OW-1:0];
  endtask

  task automatic fill(input int va, input int vb, input int c0, input int c1);
    foreach (av[i]) av[i] = va;
    foreach (bv[i]) bv[i] = vb;
    cv[0] = c0;
    cv[1] = c1;
    pack();
  endtask

  task automatic fill_rand();
    foreach (av[i]) av[i] = int'($urandom_range(255)) - 128;
    foreach (bv[i]) bv[i] = int'($urandom_range(255)) - 128;
    foreach (cv[i]) cv[i] = int'($urandom_range(255)) - 128;
    relu_en = 1'(($urandom_range(1)));
    pack();
  endtask

  // One run: stall_mode holds y_ready low 10 cycles at elements 0, 7 and last;
  // check_lat compares timing; poke re-pulses start mid-run; abort_at >= 0
  // pulls reset low when that element first appears.
  task automatic run(input bit stall_mode, input bit check_lat, input bit poke, input int abort_at);
    int idx = 0;
    int cyc = 0;
    int stall = 0;
    int pp, ps;
    bit fin = 0;
    bit seen = 0;
    @(negedge clk);
    start = 1'b1;
    y_ready = 1'b1;
    for (int t = 0; t < 3000 && !fin; t++) begin
      @(negedge clk);
      cyc++;
      start = (poke && (cyc == 100 || cyc == 101)) ? 1'b1 : 1'b0;
      if (cyc == 1) chk("busy_after_start", busy, 1);
      if (done) begin
        chk("done_count", idx, TOT);
        chk("done_busy", busy, 0);
        chk("done_valid", y_valid, 0);
        if (check_lat) chk("done_cycle", cyc, TOT*(K+2) + 1);
        fin = 1;
      end else if (y_valid) begin
        pp = idx / NPOS;
        ps = idx % NPOS;
        chk("y_data", $signed(y_data), model(pp, ps / CS, ps % CS));
        chk("y_depth", y_depth, pp);
        chk("y_pos", y_pos, ps);
        if (!seen) begin
          seen = 1;
          if (check_lat) chk("valid_cycle", cyc, 1 + idx*(K+2) + K + 1);
          if (stall_mode && (idx == 0 || idx == 7 || idx == TOT-1)) stall = 10;
          if (idx == abort_at) begin
            rst = 1'b0;
            #1;
            chk("abort_valid", y_valid, 0);
            chk("abort_busy", busy, 0);
            chk("abort_done", done, 0);
            chk("abort_data", y_data, 0);
            chk("abort_depth", y_depth, 0);
            chk("abort_pos", y_pos, 0);
            fin = 1;
          end
        end
        if (!fin) begin
          if (stall > 0) begin
            y_ready = 1'b0;
            stall--;
          end else begin
            y_ready = 1'b1;
            idx++;
            seen = 0;
          end
        end
      end else if (seen) begin
        chk("hold_valid", y_valid, 1);
      end
    end
    y_ready = 1'b1;
    start = 1'b0;
    chk("run_finished", fin, 1);
    if (abort_at < 0 && fin) begin
      @(negedge clk);
      chk("done_pulse", done, 0);
      chk("busy_idle", busy, 0);
    end
  endtask

  initial begin
    int exp2 [4];
    int k2;
    rst = 1'b0; start = 1'b0; start2 = 1'b0; relu_en = 1'b0; y_ready = 1'b1; y_ready2 = 1'b1;
    a = '0; b = '0; c = '0; a2 = '0; b2 = '0; c2 = '0;
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_valid", y_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_data", y_data, 0);
    chk("rst_depth", y_depth, 0);
    chk("rst_pos", y_pos, 0);
    chk("rst_valid2", y2_valid, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // All ones, including timing of every element and the done pulse.
    relu_en = 1'b0;
    fill(1, 1, 0, 0);
    run(0, 1, 0, -1);

    // Saturation and ReLU.
    fill(127, 127, 0, 0);
    run(0, 0, 0, -1);
    fill(127, -128, 0, 0);
    run(0, 0, 0, -1);
    relu_en = 1'b1;
    run(0, 0, 0, -1);

    // Per-depth bias with and without ReLU.
    relu_en = 1'b0;
    fill(0, 1, 5, -3);
    run(0, 0, 0, -1);
    relu_en = 1'b1;
    run(0, 0, 0, -1);

    // Backpressure on random data.
    fill_rand();
    run(1, 0, 0, -1);

    // Start pulsed mid-run must not disturb timing or count.
    relu_en = 1'b0;
    fill(1, 1, 0, 0);
    run(0, 1, 1, -1);

    // Reset in the middle of a run, then a clean full run.
    run(0, 0, 0, 10);
    @(negedge clk);
    rst = 1'b1;
    fill_rand();
    run(0, 1, 0, -1);

    // Further random runs.
    for (int r = 0; r < 3; r++) begin
      fill_rand();
      run(r == 1, 0, 0, -1);
    end

    // Strided, unpadded single-channel configuration on the second instance.
    relu_en = 1'b0;
    for (int i = 0; i < 16; i++) a2[i*8 +: 8] = 8'(i);
    b2 = {4{8'd1}};
    c2 = 8'd0;
    exp2 = '{10, 18, 42, 50};
    k2 = 0;
    @(negedge clk);
    start2 = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      start2 = 1'b0;
      if (y2_valid && k2 < 4) begin
        chk("p2_data", $signed(y2_data), exp2[k2]);
        chk("p2_pos", y2_pos, k2);
        chk("p2_depth", y2_depth, 0);
        k2++;
      end
      if (done2) break;
    end
    chk("p2_count", k2, 4);
    chk("p2_done_busy", busy2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
